// File: rtl/tc_pkg.sv
// tc_pkg: shared types and constants for the memory-mapped down-counter timer.
// Contents: FSM state enum, register offsets (addr[3:2]), CTRL bit layout,
// MODE codes and a small MODE decode helper.
// Optional feature macro: TC_AUTORELOAD_EN (see tc_regs / timer_counter).
package tc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  // Timer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Register offsets as seen on addr[3:2]; 2'b11 is reserved.
  localparam logic [1:0] OFF_CTRL   = 2'b00;
  localparam logic [1:0] OFF_PRESET = 2'b01;
  localparam logic [1:0] OFF_COUNT  = 2'b10;

  // CTRL bit indices.
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;

  // MODE codes; 2'b1x is treated as one-shot.
  localparam logic [1:0] MODE_ONESHOT    = 2'b00;
  localparam logic [1:0] MODE_AUTORELOAD = 2'b01;

  // CTRL payload, MSB first so it overlays CTRL[3:0] directly.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  // Only the exact auto-reload code reloads; everything else is one-shot.
  function automatic logic is_autoreload(input logic [1:0] mode);
    return (mode == MODE_AUTORELOAD);
  endfunction

endpackage

// File: rtl/tc_regs.sv
// tc_regs: address decode, CTRL/PRESET storage and read-data mux.
// Ports:
//   clk, reset_n   - clock, async active-low reset
//   reg_sel_i      - register select (addr[3:2])
//   we_i           - write strobe (already window-qualified)
//   wdata_i        - write data
//   count_i        - live COUNT value from the timer core (read only)
//   en_clr_i       - timer core request to clear CTRL.EN (one-shot terminal)
//   ctrl_o         - stored CTRL[3:0]
//   preset_o       - stored PRESET
//   ctrl_wr_c_o    - combinational: CTRL write happening this cycle
//   rdata_c_o      - combinational read data
// Macro TC_AUTORELOAD_EN: when undefined, MODE is forced to one-shot on write.
module tc_regs
  import tc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        reg_sel_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] count_i,
  input  logic              en_clr_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] preset_o,
  output logic              ctrl_wr_c_o,
  output logic [DATA_W-1:0] rdata_c_o
);

  tc_ctrl_t          ctrl_q, ctrl_d, ctrl_wdata_c;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic              ctrl_wr_c, preset_wr_c;

  assign ctrl_wr_c   = we_i && (reg_sel_i == OFF_CTRL);
  assign preset_wr_c = we_i && (reg_sel_i == OFF_PRESET);

  // Value a CTRL write stores; without the feature MODE always lands as one-shot.
`ifdef TC_AUTORELOAD_EN
  assign ctrl_wdata_c = tc_ctrl_t'(wdata_i[CTRL_W-1:0]);
`else
  assign ctrl_wdata_c = tc_ctrl_t'({wdata_i[CTRL_IM_BIT], MODE_ONESHOT, wdata_i[CTRL_EN_BIT]});
`endif

  // Next-state: a CPU CTRL write beats the core's EN clear in the same cycle.
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    if (ctrl_wr_c) begin
      ctrl_d = ctrl_wdata_c;
    end else if (en_clr_i) begin
      ctrl_d.en = 1'b0;
    end
    if (preset_wr_c) begin
      preset_d = wdata_i;
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      preset_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
    end
  end

  // Read mux; reserved offset reads zero.
  always_comb begin
    rdata_c_o = '0;
    case (reg_sel_i)
      OFF_CTRL:   rdata_c_o = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
      OFF_PRESET: rdata_c_o = preset_q;
      OFF_COUNT:  rdata_c_o = count_i;
      default:    rdata_c_o = '0;
    endcase
  end

  assign ctrl_o      = ctrl_q;
  assign preset_o    = preset_q;
  assign ctrl_wr_c_o = ctrl_wr_c;

endmodule

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counter timer with interrupt.
// Ports:
//   clk      - system clock
//   reset_n  - async active-low reset
//   addr     - byte address; only addr[3:2] decoded
//   we       - write strobe (window-qualified by the bridge)
//   din      - write data
//   dout     - combinational read data
//   irq      - registered interrupt request (irq_flag & CTRL.IM)
// Macro TC_AUTORELOAD_EN: enables MODE 01 auto-reload; otherwise one-shot only.
module timer_counter
  import tc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              irq
);

  tc_state_e         state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              irq_flag_q, irq_flag_d;
  logic              irq_q;
  logic              en_clr_c, flag_set_c, ctrl_wr_c;
  logic [CTRL_W-1:0] ctrl_bits;
  tc_ctrl_t          ctrl;
  logic [DATA_W-1:0] preset;

  // Address bits outside the register select are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{addr[DATA_W-1:4], addr[1:0]};

  assign ctrl = tc_ctrl_t'(ctrl_bits);

  tc_regs u_regs (
    .clk         (clk),
    .reset_n     (reset_n),
    .reg_sel_i   (addr[3:2]),
    .we_i        (we),
    .wdata_i     (din),
    .count_i     (count_q),
    .en_clr_i    (en_clr_c),
    .ctrl_o      (ctrl_bits),
    .preset_o    (preset),
    .ctrl_wr_c_o (ctrl_wr_c),
    .rdata_c_o   (dout)
  );

  // State, counter and interrupt registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_flag_q & ctrl.im;
    end
  end

  // Next-state, counter update and interrupt flag control.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    en_clr_c   = 1'b0;
    flag_set_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl.en) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        // Disable freezes COUNT; zero is the terminal count, no wrap below it.
        if (!ctrl.en) begin
          state_d = ST_IDLE;
        end else if (count_q == '0) begin
          state_d    = ST_INT;
          flag_set_c = 1'b1;
        end else begin
          count_d = count_q - DATA_W'(1);
        end
      end
      ST_INT: begin
        // Auto-reload pulses the flag and leaves EN set; one-shot holds it and stops.
        state_d = ST_IDLE;
        if (is_autoreload(ctrl.mode)) begin
          irq_flag_d = 1'b0;
        end else begin
          en_clr_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A CTRL write acknowledges the flag; a new terminal count in the same cycle wins.
    if (ctrl_wr_c) begin
      irq_flag_d = 1'b0;
    end
    if (flag_set_c) begin
      irq_flag_d = 1'b1;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: randomized self-checking bench for timer_counter.
// Expected values come from the timer's documented timing rules: with PRESET=P
// and EN written at edge 0, COUNT=P at edge 2, COUNT=P-(k-2) at edge k,
// COUNT=0 at edge P+2, irq high from edge P+4; auto-reload period is P+4.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] base;

`ifdef TC_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  always #5 clk = ~clk;

  timer_counter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .irq     (irq)
  );

  function automatic logic [31:0] a_of(input int off);
    return base | 32'(off * 4);
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    addr = a_of(off);
    din  = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
    din  = '0;
  endtask

  task automatic rd(input int off, output logic [31:0] v);
    we   = 1'b0;
    addr = a_of(off);
    #1;
    v = dout;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int p;
    reset_n = 1'b0;
    step(2);
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL reset_read[%0d]: got %h expected 0", i, v); end
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
    reset_n = 1'b1;
    step(1);

    p = int'($urandom_range(20, 40));
    wr(1, 32'(p));
    wr(0, 32'h9);
    step(6);
    rd(2, v);
    total++;
    if (v !== 32'(p - 4)) begin bad++; $display("FAIL reset_precount: got %0d expected %0d", v, p - 4); end

    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL reset_midcount_read[%0d]: got %h expected 0", i, v); end
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_midcount_irq: got %b expected 0", irq); end
    step(2);
    reset_n = 1'b1;
    step(10);
    rd(0, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reset_release_ctrl: got %h expected 0", v); end
    rd(2, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reset_release_count: got %0d expected 0", v); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_release_irq: got %b expected 0", irq); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v, c2, cp2;
    int p, rise, hi;
    for (int it = 0; it < 3; it++) begin
      p = (it == 0) ? 5 : (it == 1) ? 0 : int'($urandom_range(1, 15));
      wr(1, 32'(p));
      wr(0, 32'h9);
      rise = -1; hi = 0; c2 = '0; cp2 = '1;
      addr = a_of(2);
      for (int k = 1; k <= p + 12; k++) begin
        @(negedge clk);
        #1;
        if (irq === 1'b1) begin hi++; if (rise < 0) rise = k; end
        if (k == 2) c2 = dout;
        if (k == p + 2) cp2 = dout;
      end
      total++;
      if (rise != p + 4) begin bad++; $display("FAIL oneshot_rise p=%0d: got edge %0d expected %0d", p, rise, p + 4); end
      total++;
      if (hi != 9) begin bad++; $display("FAIL oneshot_held p=%0d: got %0d high cycles expected 9", p, hi); end
      total++;
      if (c2 !== 32'(p)) begin bad++; $display("FAIL oneshot_load p=%0d: got %0d expected %0d", p, c2, p); end
      total++;
      if (cp2 !== 32'h0) begin bad++; $display("FAIL oneshot_zero p=%0d: got %0d expected 0", p, cp2); end
      rd(0, v);
      total++;
      if (v !== 32'h8) begin bad++; $display("FAIL oneshot_ctrl p=%0d: got %h expected 8", p, v); end
      rd(2, v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL oneshot_count_end p=%0d: got %0d expected 0", p, v); end
      wr(0, 32'h8);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_ack_edge p=%0d: got %b expected 1", p, irq); end
      step(1);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_ack_fall p=%0d: got %b expected 0", p, irq); end
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic exp;
    int p, n, errs, first_bad;
    for (int it = 0; it < 2; it++) begin
      p = (it == 0) ? 3 : int'($urandom_range(1, 6));
      wr(1, 32'(p));
      wr(0, 32'hB);
      n = 4 * (p + 4) + 3;
      errs = 0; first_bad = -1;
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        exp = AR ? (k >= p + 4 && (k % (p + 4)) == 0) : (k >= p + 4);
        if (irq !== exp) begin errs++; if (first_bad < 0) first_bad = k; end
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL autoreload_pattern p=%0d ar=%0d: %0d wrong cycles, first at edge %0d", p, AR, errs, first_bad); end
      rd(0, v);
      total++;
      if (v !== (AR ? 32'hB : 32'h8)) begin bad++; $display("FAIL autoreload_ctrl p=%0d: got %h expected %h", p, v, AR ? 32'hB : 32'h8); end
      wr(0, 32'h0);
      wr(0, 32'h8);
      step(3);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL autoreload_stop p=%0d: got %b expected 0", p, irq); end
    end
  endtask

  task automatic test_mask();
    logic [31:0] v;
    int p, hi;
    p = int'($urandom_range(0, 5));
    wr(1, 32'(p));
    wr(0, 32'h1);
    hi = 0;
    for (int k = 1; k <= p + 10; k++) begin
      @(negedge clk);
      if (irq !== 1'b0) hi++;
    end
    total++;
    if (hi != 0) begin bad++; $display("FAIL mask_irq p=%0d: got %0d high cycles expected 0", p, hi); end
    rd(0, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL mask_ctrl p=%0d: got %h expected 0", p, v); end
    wr(0, 32'h8);
    hi = (irq !== 1'b0) ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (irq !== 1'b0) hi++;
    end
    total++;
    if (hi != 0) begin bad++; $display("FAIL mask_unmask p=%0d: got %0d high cycles expected 0", p, hi); end
  endtask

  task automatic test_pause();
    logic [31:0] v, junk;
    int p, p2, rise;
    p = int'($urandom_range(20, 40));
    wr(1, 32'(p));
    wr(0, 32'h9);
    step(p - 9);
    wr(0, 32'h8);
    step(5);
    rd(2, v);
    total++;
    if (v !== 32'd10) begin bad++; $display("FAIL pause_hold p=%0d: got %0d expected 10", p, v); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL pause_irq: got %b expected 0", irq); end
    wr(2, 32'h1234);
    rd(2, v);
    total++;
    if (v !== 32'd10) begin bad++; $display("FAIL count_ro: got %0d expected 10", v); end
    junk = $urandom;
    wr(3, junk);
    rd(3, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reserved_read: got %h expected 0", v); end
    rd(1, v);
    total++;
    if (v !== 32'(p)) begin bad++; $display("FAIL preset_intact: got %0d expected %0d", v, p); end

    // PRESET rewritten while counting only matters at the next LOAD.
    p  = int'($urandom_range(15, 25));
    p2 = int'($urandom_range(3, 12));
    wr(1, 32'(p));
    wr(0, 32'h9);
    step(4);
    wr(1, 32'(p2));
    rd(2, v);
    total++;
    if (v !== 32'(p - 3)) begin bad++; $display("FAIL preset_midcount_count: got %0d expected %0d", v, p - 3); end
    rd(1, v);
    total++;
    if (v !== 32'(p2)) begin bad++; $display("FAIL preset_readback: got %0d expected %0d", v, p2); end
    rise = -1;
    for (int k = 6; k <= p + 10; k++) begin
      @(negedge clk);
      if (irq === 1'b1 && rise < 0) rise = k;
    end
    total++;
    if (rise != p + 4) begin bad++; $display("FAIL preset_midcount_rise: got edge %0d expected %0d", rise, p + 4); end
    wr(0, 32'h9);
    step(2);
    rd(2, v);
    total++;
    if (v !== 32'(p2)) begin bad++; $display("FAIL preset_nextload: got %0d expected %0d", v, p2); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL restart_irq_cleared: got %b expected 0", irq); end
    rise = -1;
    for (int k = 3; k <= p2 + 10; k++) begin
      @(negedge clk);
      if (irq === 1'b1 && rise < 0) rise = k;
    end
    total++;
    if (rise != p2 + 4) begin bad++; $display("FAIL preset_nextload_rise: got edge %0d expected %0d", rise, p2 + 4); end
    wr(0, 32'h8);
    step(2);
  endtask

  task automatic test_collision();
    logic [31:0] v;
    int p, rise;
    p = int'($urandom_range(1, 6));
    wr(1, 32'(p));
    wr(0, 32'h9);
    step(p + 3);
    wr(0, 32'h9);
    rd(0, v);
    total++;
    if (v !== 32'h9) begin bad++; $display("FAIL collision_ctrl p=%0d: got %h expected 9", p, v); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL collision_irq_edge p=%0d: got %b expected 1", p, irq); end
    step(1);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL collision_flag_clear p=%0d: got %b expected 0", p, irq); end
    rise = -1;
    for (int k = 2; k <= p + 12; k++) begin
      @(negedge clk);
      if (irq === 1'b1 && rise < 0) rise = k;
    end
    total++;
    if (rise != p + 4) begin bad++; $display("FAIL collision_reload_rise p=%0d: got edge %0d expected %0d", p, rise, p + 4); end
    rd(0, v);
    total++;
    if (v !== 32'h8) begin bad++; $display("FAIL collision_end_ctrl p=%0d: got %h expected 8", p, v); end
    wr(0, 32'h8);
    step(2);
  endtask

  initial begin
    base = ($urandom_range(0, 1) == 1) ? 32'h7F10 : 32'h7F00;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_autoreload();
    test_mask();
    test_pause();
    test_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
